// File: rtl/pacman_pkg.sv
// Shared pac-man definitions: direction and tile codes, FSM states, and the
// reset-time maze image with its pellet count.
package pacman_pkg;

  localparam int MAZE_COLS  = 28;
  localparam int MAZE_ROWS  = 31;
  localparam int ROW_TUNNEL = 14;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    WALL = 2'd0,
    WKNP = 2'd1,
    WKRP = 2'd2,
    WKGH = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } maze_state_t;

  typedef logic [MAZE_ROWS-1:0][MAZE_COLS-1:0][1:0] maze_t;

  // '#' wall, '.' pellet, 'G' ghost house, ' ' walkable without pellet
  function automatic logic [8*MAZE_COLS-1:0] row_art(input int r);
    case (r)
      0, 30:           row_art = "############################";
      1, 20:           row_art = "#............##............#";
      2, 3, 4, 21, 22: row_art = "#.####.#####.##.#####.####.#";
      5, 27, 29:       row_art = "#..........................#";
      6, 7:            row_art = "#.####.##.########.##.####.#";
      8:               row_art = "#......##....##....##......#";
      9, 10:           row_art = "######.##### ## #####.######";
      11, 17:          row_art = "######.##          ##.######";
      12:              row_art = "######.## ###GG### ##.######";
      13, 15:          row_art = "######.## #GGGGGG# ##.######";
      14:              row_art = "      .   #GGGGGG#   .      ";
      16, 18, 19:      row_art = "######.## ######## ##.######";
      23:              row_art = "#...##................##...#";
      24:              row_art = "###.##.##.########.##.##.###";
      25:              row_art = "#......##..........##......#";
      26:              row_art = "#.##########....##########.#";
      28:              row_art = "#.##########.##.##########.#";
      default:         row_art = "############################";
    endcase
  endfunction

  function automatic logic [1:0] char_tile(input logic [7:0] ch);
    case (ch)
      "#":     return WALL;
      ".":     return WKRP;
      "G":     return WKGH;
      default: return WKNP;
    endcase
  endfunction

  function automatic maze_t build_maze();
    maze_t m;
    logic [8*MAZE_COLS-1:0] art;
    m = '0;
    for (int r = 0; r < MAZE_ROWS; r++) begin
      art = row_art(r);
      for (int c = 0; c < MAZE_COLS; c++)
        m[r][c] = char_tile(art[8*(MAZE_COLS-1-c) +: 8]);
    end
    return m;
  endfunction

  localparam maze_t MAZE_INIT = build_maze();

  function automatic int count_pellets();
    int n;
    n = 0;
    for (int r = 0; r < MAZE_ROWS; r++)
      for (int c = 0; c < MAZE_COLS; c++)
        if (MAZE_INIT[r][c] == WKRP) n++;
    return n;
  endfunction

  localparam int PELLET_TOTAL = count_pellets();

endpackage

// File: rtl/maze_neighbour_lookup.sv
// Four-way neighbour fetch around a tile, with edge-as-wall and the
// left/right wrap through the tunnel row.
module maze_neighbour_lookup
  import pacman_pkg::*;
#(
  parameter int COLS = 28,
  parameter int ROWS = 31
) (
  input  logic [6:0]                       xtile_i,
  input  logic [6:0]                       ytile_i,
  input  logic [ROWS-1:0][COLS-1:0][1:0]   map_i,
  output logic [1:0]                       nb_o [0:3]
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [7:0] COLS8 = 8'(COLS);
  localparam logic [7:0] ROWS8 = 8'(ROWS);
  localparam logic [7:0] TUN8  = 8'(ROW_TUNNEL);

  function automatic logic [1:0] tile_at(input logic [ROWS-1:0][COLS-1:0][1:0] m,
                                         input logic [7:0] cx,
                                         input logic [7:0] cy);
    if (cx < COLS8 && cy < ROWS8) return m[cy[YW-1:0]][cx[XW-1:0]];
    return WALL;
  endfunction

  logic [7:0] x8;
  logic [7:0] y8;
  logic       on_tunnel;
  logic       off_screen;

  always_comb begin
    x8         = {1'b0, xtile_i};
    y8         = {1'b0, ytile_i};
    on_tunnel  = (y8 == TUN8);
    off_screen = on_tunnel && (x8 >= COLS8);

    nb_o[DIR_RIGHT] = (on_tunnel && x8 == COLS8 - 8'd1) ? map_i[ROW_TUNNEL][0]
                                                         : tile_at(map_i, x8 + 8'd1, y8);
    nb_o[DIR_UP]    = (y8 == 8'd0) ? WALL : tile_at(map_i, x8, y8 - 8'd1);
    nb_o[DIR_DOWN]  = tile_at(map_i, x8, y8 + 8'd1);
    nb_o[DIR_LEFT]  = (x8 == 8'd0) ? (on_tunnel ? map_i[ROW_TUNNEL][COLS-1] : WALL)
                                   : tile_at(map_i, x8 - 8'd1, y8);

    // inside the tunnel but off-screen: only the corridor continues
    if (off_screen) begin
      nb_o[DIR_RIGHT] = WKNP;
      nb_o[DIR_UP]    = WALL;
      nb_o[DIR_DOWN]  = WALL;
      nb_o[DIR_LEFT]  = WKNP;
    end
  end

endmodule

// File: rtl/maze_tracker.sv
// Live maze map for pac-man: neighbour lookup, pellet eating, score keeping,
// and a registered renderer read port.
//   state    | meaning
//   ST_INIT  | copying MAZE_INIT one row per cycle
//   ST_RUN   | play, pellets are eaten
//   ST_CLEAR | all pellets gone, held until reset
module maze_tracker
  import pacman_pkg::*;
#(
  parameter int COLS          = 28,
  parameter int ROWS          = 31,
  parameter int PELLET_POINTS = 10
) (
  input  logic        clk60,
  input  logic        reset,
  input  logic [6:0]  curr_xtile,
  input  logic [6:0]  curr_ytile,
  input  logic [6:0]  rd_xtile,
  input  logic [6:0]  rd_ytile,
  output logic [1:0]  tile_info [0:3],
  output logic [1:0]  rd_tile,
  output logic        ready,
  output logic        pellet_eaten,
  output logic [15:0] score,
  output logic [9:0]  pellets_left,
  output logic        maze_clear
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [6:0] COLS7 = 7'(COLS);
  localparam logic [6:0] ROWS7 = 7'(ROWS);

  maze_state_t                      state_q;
  logic [YW-1:0]                    row_q;
  logic [ROWS-1:0][COLS-1:0][1:0]   map_q;
  logic [15:0]                      score_q, score_d;
  logic [9:0]                       pellets_left_q;
  logic                             pellet_eaten_q;
  logic                             maze_clear_q;
  logic                             ready_q;
  logic [1:0]                       rd_tile_q, rd_tile_d;

  logic [XW-1:0] cur_x, rd_x;
  logic [YW-1:0] cur_y, rd_y;
  logic          cur_in, rd_in, eat;
  logic [16:0]   score_sum;
  logic [1:0]    nb [0:3];

  assign cur_x  = curr_xtile[XW-1:0];
  assign cur_y  = curr_ytile[YW-1:0];
  assign rd_x   = rd_xtile[XW-1:0];
  assign rd_y   = rd_ytile[YW-1:0];
  assign cur_in = (curr_xtile < COLS7) && (curr_ytile < ROWS7);
  assign rd_in  = (rd_xtile < COLS7) && (rd_ytile < ROWS7);
  assign eat    = (state_q == ST_RUN) && cur_in && (map_q[cur_y][cur_x] == WKRP);

  assign score_sum = {1'b0, score_q} + 17'(PELLET_POINTS);
  assign score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  maze_neighbour_lookup #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_lookup (
    .xtile_i (curr_xtile),
    .ytile_i (curr_ytile),
    .map_i   (map_q),
    .nb_o    (nb)
  );

  always_comb begin
    for (int i = 0; i < 4; i++)
      tile_info[i] = (state_q == ST_INIT) ? WALL : nb[i];
  end

  // rows not yet copied still hold stale data, so mask them during INIT
  always_comb begin
    rd_tile_d = WALL;
    if (rd_in) begin
      if (state_q != ST_INIT || rd_y < row_q) rd_tile_d = map_q[rd_y][rd_x];
      if (eat && rd_x == cur_x && rd_y == cur_y) rd_tile_d = WKNP;
    end
  end

  always_ff @(posedge clk60) begin
    if (reset) begin
      state_q        <= ST_INIT;
      row_q          <= '0;
      score_q        <= '0;
      pellets_left_q <= 10'(PELLET_TOTAL);
      pellet_eaten_q <= 1'b0;
      maze_clear_q   <= 1'b0;
      ready_q        <= 1'b0;
      rd_tile_q      <= WALL;
    end else begin
      rd_tile_q      <= rd_tile_d;
      pellet_eaten_q <= eat;
      case (state_q)
        ST_INIT: begin
          map_q[row_q] <= MAZE_INIT[row_q];
          if (row_q == YW'(ROWS-1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (eat) begin
            map_q[cur_y][cur_x] <= WKNP;
            score_q             <= score_d;
            pellets_left_q      <= pellets_left_q - 1'b1;
            if (pellets_left_q == 10'd1) begin
              state_q      <= ST_CLEAR;
              maze_clear_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_tile      = rd_tile_q;
  assign ready        = ready_q;
  assign pellet_eaten = pellet_eaten_q;
  assign score        = score_q;
  assign pellets_left = pellets_left_q;
  assign maze_clear   = maze_clear_q;

endmodule

// File: doc/maze_tracker.md
# maze_tracker

Holds the live maze map that feeds pac-man motion. Each cycle it returns the four neighbour tile types of the tile pac-man occupies, clears pellets pac-man walks over, and keeps score and pellet count. It sits directly upstream of the pac-man motion block: it consumes that block's `curr_xtile`/`curr_ytile` and drives its `tile_info[0:3]`. A second, registered read port serves the maze renderer.

## Interface
Parameters:
- `COLS`, default 28: maze width in tiles.
- `ROWS`, default 31: maze height in tiles.
- `PELLET_POINTS`, default 10: score added per pellet.

Ports:
- `clk60` in 1: 60 Hz game clock.
- `reset` in 1: synchronous, active-high; reloads the maze.
- `curr_xtile` in 7: pac-man tile column.
- `curr_ytile` in 7: pac-man tile row.
- `rd_xtile` in 7: renderer read column.
- `rd_ytile` in 7: renderer read row.
- `tile_info[0:3]` out 2 each: neighbour types, indexed by direction code (RIGHT=0, UP=1, DOWN=2, LEFT=3).
- `rd_tile` out 2: renderer read data.
- `ready` out 1: maze loaded, game may start.
- `pellet_eaten` out 1: one-cycle pulse per pellet cleared.
- `score` out 16: accumulated score.
- `pellets_left` out 10: remaining pellets.
- `maze_clear` out 1: all pellets eaten.

## Operation
- Tile codes: WALL=0, WKNP=1, WKRP=2, WKGH=3.
- Map storage: ROWS×COLS×2-bit registers, row-addressable.
- States:
  - INIT: copies one row of `MAZE_INIT` per cycle, rows 0→ROWS-1; after row ROWS-1 goes to RUN.
  - RUN: normal play.
  - CLEAR: terminal until `reset`.
- `reset` in any state: go to INIT, row 0; `score`=0; `pellets_left`=`PELLET_TOTAL`; `maze_clear`=0; `pellet_eaten`=0; `ready`=0. Reset mid-INIT restarts the copy.
- `ready`=1 only in RUN and CLEAR.
- Neighbours of (x,y): RIGHT (x+1,y), UP (x,y-1), DOWN (x,y+1), LEFT (x-1,y).
- Any neighbour outside 0..COLS-1 / 0..ROWS-1 reads WALL, with one exception for the tunnel row `ROW_TUNNEL` (14):
  - LEFT of x=0 reads tile (COLS-1,14); RIGHT of x=COLS-1 reads tile (0,14).
  - Pac-man at x≥COLS on row 14 (off-screen, including 7-bit underflow such as x=127): LEFT and RIGHT read WKNP, UP and DOWN read WALL.
- Eating, in RUN only: if the current tile is in range and stores WKRP:
  - Write WKNP to that tile.
  - Add `PELLET_POINTS` to `score`, saturating at 65535.
  - Decrement `pellets_left`.
  - Assert `pellet_eaten` next cycle.
  - If `pellets_left` was 1, go to CLEAR and set `maze_clear`.
- Out-of-range current tile: no write, no score.
- No eating in INIT or CLEAR.
- Renderer reads during INIT return rows already copied, or WALL for rows not yet copied.

## Timing
- `tile_info`: combinational from `curr_xtile`/`curr_ytile` and the stored map, valid in the same cycle. Forced to all WALL while in INIT.
- Eat write, `score`, `pellets_left`, `pellet_eaten`, `maze_clear`: all update on the same `clk60` edge that samples the WKRP current tile.
- Pac-man stays on a tile for several cycles; the tile is WKNP after the first edge, so one pellet scores exactly once.
- `rd_tile`: 1-cycle latency from `rd_xtile`/`rd_ytile`. If it reads the tile being eaten on the same edge, it returns the new value (WKNP). `rd_tile` resets to WALL.
- INIT lasts exactly ROWS cycles; `ready` rises on cycle ROWS after `reset` deasserts.

## Structure
- Shared package `pacman_pkg` holds:
  - direction codes and tile codes;
  - `MAZE_INIT` as a constant array [ROWS][COLS];
  - `PELLET_TOTAL`, equal to the WKRP count of `MAZE_INIT`;
  - `ROW_TUNNEL`.
- One sub-module, `maze_neighbour_lookup`: combinational in-range checks, tunnel wrap, and 4-way neighbour mux. It is instantiated once.
- The FSM, storage, and counters stay in `maze_tracker`.

## Test plan
- Reset, then hold 40 cycles → `ready`=0 for cycles 0–30 and 1 from cycle 31; `score`=0; `pellets_left`=`PELLET_TOTAL`.
- Pac-man at (14,25) in RUN → `tile_info` matches `MAZE_INIT` neighbours. Set (1,1) holding WKRP for 5 cycles → exactly one `pellet_eaten` pulse, `score`=10, `pellets_left` reduced by 1, renderer read of (1,1) returns WKNP.
- Tunnel: (0,14) → LEFT equals tile (27,14); (27,14) → RIGHT equals tile (0,14); x=127 on row 14 → {WKNP, WALL, WALL, WKNP}.
- Out of range: (5,40) → all WALL, no score change. Any position during INIT → all WALL.
- Force `pellets_left`=1 and eat → `maze_clear`=1 and state is CLEAR; a further WKRP tile leaves `score` unchanged.
- Assert `reset` at INIT row 10 and again mid-RUN → restart at row 0, `score`=0, previously eaten tiles restored to WKRP.
